// File: rtl/dbi_bus_arbiter_if.sv
// Requester-side and bus-side handshake bundle for the DBI bus arbiter.
// slave = arbiter, master = the requesters plus the downstream bus consumer.
interface dbi_bus_arbiter_if #(
  parameter int BW   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*BW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [BW:0]        bus_data;
  logic               bus_valid;
  logic [IDW-1:0]     bus_id;
  logic               bus_ready;

  modport master (
    output req_valid, req_data, bus_ready,
    input  req_ready, bus_data, bus_valid, bus_id
  );

  modport slave (
    input  req_valid, req_data, bus_ready,
    output req_ready, bus_data, bus_valid, bus_id
  );
endinterface

// File: rtl/dbi_bus_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one DBI-AC encoded bus; 1 cycle to arbitrate,
// accepted word appears on the bus the next cycle; stalls requesters while a held word is not taken.
module dbi_bus_arbiter #(
  parameter int BW   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dbi_en,
  input  logic [3:0]           burst_len,
  dbi_bus_arbiter_if.slave     bus,
  output logic [15:0]          inv_count
);
  localparam int CW = $clog2(BW + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [4:0]      burst_cnt_q, burst_cnt_d;
  logic [BW-1:0]   last_word_q, last_word_d;
  logic [BW:0]     bus_data_q, bus_data_d;
  logic            bus_valid_q, bus_valid_d;
  logic [IDW-1:0]  bus_id_q, bus_id_d;
  logic [15:0]     inv_count_q, inv_count_d;

  logic            slot_free, grant_vld, accept, last_acc, rel, any_req, found, flip;
  logic [4:0]      burst_lim;
  logic [IDW-1:0]  pick, idx;
  logic [BW-1:0]   acc_word;
  logic [CW-1:0]   diff;
  logic [BW:0]     enc_word;

  assign any_req   = |bus.req_valid;
  assign slot_free = !bus_valid_q || bus.bus_ready;
  assign grant_vld = bus.req_valid[grant_q];
  assign accept    = (state_q == XFER) && grant_vld && slot_free;
  assign burst_lim = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
  assign last_acc  = accept && ((burst_cnt_q + 5'd1) == burst_lim);
  assign rel       = (state_q == XFER) && (last_acc || (slot_free && !grant_vld));
  assign acc_word  = bus.req_data[grant_q*BW +: BW];

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Toggle count is measured against the payload actually driven last time.
  always_comb begin
    diff = '0;
    for (int i = 0; i < BW; i++) begin
      diff = diff + CW'(acc_word[i] ^ last_word_q[i]);
    end
    flip     = dbi_en && (diff > CW'(BW / 2));
    enc_word = flip ? {1'b1, ~acc_word} : {1'b0, acc_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (rel)     state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == XFER) begin
      bus.req_ready[grant_q] = slot_free;
    end
  end

  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE && any_req) begin
      grant_d     = pick;
      burst_cnt_d = 5'd0;
    end
    if (accept) burst_cnt_d = burst_cnt_q + 5'd1;
    if (rel)    rr_ptr_d    = grant_q + IDW'(1);

    bus_valid_d = accept ? 1'b1 : (bus.bus_ready ? 1'b0 : bus_valid_q);
    bus_data_d  = accept ? enc_word : bus_data_q;
    bus_id_d    = accept ? grant_q : bus_id_q;
    last_word_d = accept ? enc_word[BW-1:0] : last_word_q;
    inv_count_d = inv_count_q;
    if (accept && flip && inv_count_q != 16'hFFFF) inv_count_d = inv_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_word_q <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_id_q    <= '0;
      inv_count_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_word_q <= last_word_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      bus_id_q    <= bus_id_d;
      inv_count_q <= inv_count_d;
    end
  end

  assign bus.bus_data  = bus_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_id    = bus_id_q;
  assign inv_count     = inv_count_q;
endmodule

// File: tb/tb_dbi_bus_arbiter.sv
// Scoreboard bench for dbi_bus_arbiter: accepted words are encoded by a reference model and
// queued; every word leaving the bus is popped and compared.
module tb_dbi_bus_arbiter;
  localparam int BW = 16, NREQ = 4, IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [BW:0]    dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbi_en;
  logic [3:0]  burst_len;
  logic [15:0] inv_count;

  dbi_bus_arbiter_if #(.BW(BW), .NREQ(NREQ), .IDW(IDW)) bif ();

  dbi_bus_arbiter #(.BW(BW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .dbi_en    (dbi_en),
    .burst_len (burst_len),
    .bus       (bif),
    .inv_count (inv_count)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_err = 0, cyc = 0, first_vld = -1, m_inv = 0, c0 = 0, nexp = 0;
  logic [BW-1:0] src_q [NREQ][$];
  beat_t         sb_q[$];
  beat_t         obs_q[$];
  int            obs_cyc[$];
  logic [BW-1:0] m_last = '0;
  logic          br_next = 1'b1, rst_next = 1'b1, hold_pend = 1'b0;
  beat_t         hold_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [BW:0] dbi_ref(input logic [BW-1:0] d, input logic [BW-1:0] last,
                                          input logic en);
    if (en && $countones(d ^ last) > BW / 2) return {1'b1, ~d};
    return {1'b0, d};
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bif.req_valid[i]           = (src_q[i].size() != 0);
      bif.req_data[i*BW +: BW]   = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  // Observe at the falling edge, then drive fresh inputs just after the rising edge.
  task automatic cycle();
    logic [NREQ-1:0] hs;
    logic [BW-1:0]   w;
    beat_t           b, e;
    @(negedge clk);
    if (reset) begin
      hold_pend = 1'b0;
      sb_q.delete();
      m_last = '0;
      m_inv  = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_dat", 32'(bif.bus_data), 32'(hold_b.dat));
        chk("hold_id", 32'(bif.bus_id), 32'(hold_b.id));
      end
      hold_pend = bif.bus_valid && !bif.bus_ready;
      hold_b    = '{id: bif.bus_id, dat: bif.bus_data};
      if (hold_pend) chk("stall_rdy", 32'(bif.req_ready), 32'd0);
      if (bif.bus_valid && first_vld < 0) first_vld = cyc;
      if (bif.bus_valid && bif.bus_ready) begin
        b = '{id: bif.bus_id, dat: bif.bus_data};
        obs_q.push_back(b);
        obs_cyc.push_back(cyc);
        if (sb_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("sb_id", 32'(b.id), 32'(e.id));
          chk("sb_dat", 32'(b.dat), 32'(e.dat));
        end
      end
      hs = bif.req_valid & bif.req_ready;
      if (hs != '0) chk("hs_onehot", 32'($countones(hs)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          w      = src_q[i].pop_front();
          e.dat  = dbi_ref(w, m_last, dbi_en);
          e.id   = IDW'(i);
          m_last = e.dat[BW-1:0];
          if (e.dat[BW]) m_inv++;
          sb_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    reset         = rst_next;
    bif.bus_ready = br_next;
    drive_reqs();
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    cycle();
    cycle();
    rst_next = 1'b0;
    cycle();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    first_vld = -1;
  endtask

  initial begin
    reset = 1'b1; dbi_en = 1'b1; burst_len = 4'd0;
    bif.req_valid = '0; bif.req_data = '0; bif.bus_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_vld", 32'(bif.bus_valid), 32'd0);
    chk("rst_dat", 32'(bif.bus_data), 32'd0);
    chk("rst_id", 32'(bif.bus_id), 32'd0);
    chk("rst_inv", 32'(inv_count), 32'd0);
    chk("rst_rdy", 32'(bif.req_ready), 32'd0);

    // First word: inverted, two-cycle latency from req_valid to bus_valid.
    src_q[0].push_back(16'hFFFF);
    rst_next = 1'b0;
    clear_obs();
    cycle();
    c0 = cyc;
    wait_obs(1, 20, "t1_timeout");
    chk("t1_lat", 32'(first_vld - c0), 32'd2);
    chk("t1_dat", 32'(obs_q[0].dat), 32'h10000);
    chk("t1_id", 32'(obs_q[0].id), 32'd0);
    chk("t1_inv", 32'(inv_count), 32'd1);

    // Tie at 8 toggles keeps polarity; 15 toggles inverts.
    src_q[0].push_back(16'h00FF);
    src_q[0].push_back(16'hFF01);
    wait_obs(3, 30, "t2_timeout");
    chk("t2_tie", 32'(obs_q[1].dat), 32'h000FF);
    chk("t2_thr", 32'(obs_q[2].dat), 32'h100FE);
    chk("t2_inv", 32'(inv_count), 32'd2);

    // Encoding disabled: raw words, flag clear.
    dbi_en = 1'b0;
    src_q[1].push_back(16'hAAAA);
    src_q[1].push_back(16'h5555);
    wait_obs(5, 30, "t3_timeout");
    chk("t3_w0", 32'(obs_q[3].dat), 32'h0AAAA);
    chk("t3_id", 32'(obs_q[3].id), 32'd1);
    chk("t3_w1", 32'(obs_q[4].dat), 32'h05555);
    chk("t3_inv", 32'(inv_count), 32'd2);
    repeat (3) cycle();
    chk("t3_drain", 32'(sb_q.size()), 32'd0);

    // All requesters busy with burst_len=2: pairs per id, one idle cycle between bursts.
    dbi_en = 1'b1;
    do_reset();
    burst_len = 4'd2;
    clear_obs();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(16'($urandom));
    wait_obs(16, 200, "t4_timeout");
    for (int k = 0; k < 16; k++) chk("t4_id", 32'(obs_q[k].id), 32'((k / 2) % NREQ));
    for (int k = 1; k < 16; k++)
      chk("t4_gap", 32'(obs_cyc[k] - obs_cyc[k-1]), (k % 2 == 0) ? 32'd2 : 32'd1);

    // Downstream stall of 3 cycles while a word is held.
    burst_len = 4'd0;
    clear_obs();
    src_q[3].push_back(16'h1234);
    src_q[3].push_back(16'hABCD);
    src_q[3].push_back(16'h0F0F);
    src_q[3].push_back(16'hF00F);
    wait_obs(1, 20, "t5_timeout0");
    br_next = 1'b0;
    cycle();
    chk("t5_held", 32'(bif.bus_valid), 32'd1);
    cycle();
    cycle();
    br_next = 1'b1;
    wait_obs(4, 40, "t5_timeout1");
    repeat (5) cycle();
    chk("t5_nodup", 32'(obs_q.size()), 32'd4);
    chk("t5_drain", 32'(sb_q.size()), 32'd0);

    // Reset mid-burst of req2, then req0 wins against req2.
    do_reset();
    clear_obs();
    for (int j = 0; j < 8; j++) src_q[2].push_back(16'hFFFF);
    wait_obs(2, 30, "t6_timeout0");
    chk("t6_inv_pre", 32'(inv_count), 32'(m_inv));
    rst_next = 1'b1;
    cycle();
    src_q[0].push_back(16'h0001);
    rst_next = 1'b0;
    cycle();
    chk("t6_rst_vld", 32'(bif.bus_valid), 32'd0);
    chk("t6_rst_inv", 32'(inv_count), 32'd0);
    clear_obs();
    nexp = src_q[0].size() + src_q[2].size();
    wait_obs(nexp, 300, "t6_timeout1");
    chk("t6_first_id", 32'(obs_q[0].id), 32'd0);
    repeat (3) cycle();
    chk("t6_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
